mem_arbiter: RTL

Byte-serial memory arbiter that shares the single 8-bit RAM port between the instruction fetch unit and the load/store unit. It sequences 1/2/4-byte reads and writes over the synchronous RAM bus, assembles or serialises 32-bit words little-endian, and returns one-cycle completion pulses to each requester. It sits between IF/LSU and the top-level RAM pins, and honours the global `rdy` stall.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester ports of IF and LSU plus the byte-wide RAM bus.
// The arbiter takes the slave side; the core/RAM side takes master.
interface mem_arbiter_if;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_size;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    modport master (
        output flush, if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        output mem_din,
        input  if_data, if_done, ls_rdata, ls_done,
        input  mem_a, mem_dout, mem_wr
    );

    modport slave (
        input  flush, if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        input  mem_din,
        output if_data, if_done, ls_rdata, ls_done,
        output mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial IF/LSU arbiter for the shared 8-bit RAM port.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise LSU wins.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t      state, state_n;
    logic        own_if, own_if_n;
    logic [2:0]  num, num_n;
    logic [2:0]  iss, iss_n;
    logic [2:0]  cap, cap_n;
    logic [31:0] base, base_n;
    logic [31:0] wdat, wdat_n;
    logic [31:0] word, word_n;
    logic        abus, abus_n;
    logic        dvld, dvld_n;
    logic [31:0] mem_a_r, mem_a_n;
    logic [7:0]  mem_dout_r, mem_dout_n;
    logic        mem_wr_r, mem_wr_n;
    logic [31:0] if_data_r, if_data_n;
    logic [31:0] ls_rdata_r, ls_rdata_n;
    logic        if_done_r, if_done_n;
    logic        ls_done_r, ls_done_n;
    logic        if_ok;
    logic        pick_ls;

    function automatic logic [2:0] norm_size(input logic [2:0] s);
        if (s == 3'd0)
            return 3'd1;
        else if (s > 3'd4)
            return 3'd4;
        return s;
    endfunction

    assign if_ok = bus.if_req & ~bus.flush;

`ifdef MEM_ARB_RR_EN
    logic last_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_if <= 1'b1;
        else if (rdy && state == IDLE && (if_ok || bus.ls_req))
            last_if <= ~pick_ls;
    end

    assign pick_ls = bus.ls_req & (~if_ok | last_if);
`else
    assign pick_ls = bus.ls_req;
`endif

    // abus: a read address is on mem_a; dvld: its byte is on mem_din.
    always_comb begin
        state_n    = state;
        own_if_n   = own_if;
        num_n      = num;
        iss_n      = iss;
        cap_n      = cap;
        base_n     = base;
        wdat_n     = wdat;
        word_n     = word;
        abus_n     = 1'b0;
        dvld_n     = abus;
        mem_a_n    = mem_a_r;
        mem_dout_n = mem_dout_r;
        mem_wr_n   = 1'b0;
        if_data_n  = if_data_r;
        ls_rdata_n = ls_rdata_r;
        if_done_n  = 1'b0;
        ls_done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                mem_a_n = 32'h0;
                if (if_ok || bus.ls_req) begin
                    own_if_n = ~pick_ls;
                    base_n   = pick_ls ? bus.ls_addr : bus.if_addr;
                    num_n    = pick_ls ? norm_size(bus.ls_size) : 3'd4;
                    wdat_n   = bus.ls_wdata;
                    word_n   = 32'h0;
                    iss_n    = 3'd1;
                    cap_n    = 3'd0;
                    mem_a_n  = base_n;
                    if (pick_ls && bus.ls_we) begin
                        state_n    = WRITE;
                        mem_wr_n   = 1'b1;
                        mem_dout_n = bus.ls_wdata[7:0];
                    end else begin
                        state_n = READ;
                        abus_n  = 1'b1;
                    end
                end
            end
            READ: begin
                if (iss < num) begin
                    mem_a_n = base + {30'd0, iss[1:0]};
                    iss_n   = iss + 3'd1;
                    abus_n  = 1'b1;
                end
                if (dvld) begin
                    word_n[{cap[1:0], 3'b000} +: 8] = bus.mem_din;
                    cap_n = cap + 3'd1;
                    if (cap_n == num) begin
                        state_n = FIN;
                        mem_a_n = 32'h0;
                        if (own_if) begin
                            if_done_n = 1'b1;
                            if_data_n = word_n;
                        end else begin
                            ls_done_n  = 1'b1;
                            ls_rdata_n = word_n;
                        end
                    end
                end
                if (own_if && bus.flush) begin
                    state_n   = IDLE;
                    mem_a_n   = 32'h0;
                    abus_n    = 1'b0;
                    dvld_n    = 1'b0;
                    if_done_n = 1'b0;
                    if_data_n = if_data_r;
                end
            end
            WRITE: begin
                if (iss < num) begin
                    mem_a_n    = base + {30'd0, iss[1:0]};
                    mem_dout_n = wdat[{iss[1:0], 3'b000} +: 8];
                    mem_wr_n   = 1'b1;
                    iss_n      = iss + 3'd1;
                end else begin
                    state_n   = FIN;
                    mem_a_n   = 32'h0;
                    ls_done_n = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
                mem_a_n = 32'h0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            own_if     <= 1'b0;
            num        <= 3'd0;
            iss        <= 3'd0;
            cap        <= 3'd0;
            base       <= 32'h0;
            wdat       <= 32'h0;
            word       <= 32'h0;
            abus       <= 1'b0;
            dvld       <= 1'b0;
            mem_a_r    <= 32'h0;
            mem_dout_r <= 8'h0;
            mem_wr_r   <= 1'b0;
            if_data_r  <= 32'h0;
            ls_rdata_r <= 32'h0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
        end else if (rdy) begin
            state      <= state_n;
            own_if     <= own_if_n;
            num        <= num_n;
            iss        <= iss_n;
            cap        <= cap_n;
            base       <= base_n;
            wdat       <= wdat_n;
            word       <= word_n;
            abus       <= abus_n;
            dvld       <= dvld_n;
            mem_a_r    <= mem_a_n;
            mem_dout_r <= mem_dout_n;
            mem_wr_r   <= mem_wr_n;
            if_data_r  <= if_data_n;
            ls_rdata_r <= ls_rdata_n;
            if_done_r  <= if_done_n;
            ls_done_r  <= ls_done_n;
        end
    end

    // A flush arriving in the FIN cycle still kills the fetch completion.
    assign bus.if_done  = if_done_r & ~bus.flush;
    assign bus.if_data  = if_data_r;
    assign bus.ls_done  = ls_done_r;
    assign bus.ls_rdata = ls_rdata_r;
    assign bus.mem_a    = mem_a_r;
    assign bus.mem_dout = mem_dout_r;
    assign bus.mem_wr   = mem_wr_r;
endmodule
